// File: rtl/gat_feat_bram_reader.sv
// gat_feat_bram_reader: sweeps BRAM port B after gat_ready and streams the words out with row-end marking
module gat_feat_bram_reader #(
    parameter int NEW_FEATURE_WIDTH  = 32,
    parameter int NUM_SUBGRAPHS      = 2708,
    parameter int NUM_FEATURE_OUT    = 16,
    parameter int NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
    parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
    parameter int BRAM_RD_LAT        = 2,
    parameter int FIFO_DEPTH         = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            gat_ready,
    output logic                            busy,
    output logic                            done,
    output logic [NEW_FEATURE_ADDR_W+1:0]   feat_bram_addrb,
    input  logic [NEW_FEATURE_WIDTH-1:0]    feat_bram_dout,
    output logic [NEW_FEATURE_WIDTH-1:0]    m_tdata,
    output logic                            m_tvalid,
    input  logic                            m_tready,
    output logic                            m_tlast
);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam int COLW = NUM_FEATURE_OUT > 1 ? $clog2(NUM_FEATURE_OUT) : 1;
    localparam logic [NEW_FEATURE_ADDR_W-1:0] LAST_IDX = NEW_FEATURE_ADDR_W'(NEW_FEATURE_DEPTH - 1);
    localparam logic [COLW-1:0] LAST_COL = COLW'(NUM_FEATURE_OUT - 1);

    typedef enum logic [2:0] {IDLE, WAIT_RDY, ISSUE, DRAIN, DONE} state_t;

    state_t                         state_q, state_d;
    logic [NEW_FEATURE_ADDR_W-1:0]  rd_idx_q;
    logic [NEW_FEATURE_ADDR_W+1:0]  addrb_q;
    logic [BRAM_RD_LAT-1:0]         tag_q;
    logic [BRAM_RD_LAT:0]           tag_sh;
    logic [NEW_FEATURE_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0]                  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]                  cnt_q, inflight;
    logic [COLW-1:0]                col_q;
    logic                           issue, push, pop;

    // Reads still travelling through the BRAM pipeline hold FIFO credit until captured.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < BRAM_RD_LAT; i++) inflight = inflight + CW'(tag_q[i]);
    end

    assign issue           = (state_q == ISSUE) && (32'(cnt_q) + 32'(inflight) < FIFO_DEPTH);
    assign tag_sh          = {tag_q, issue};
    assign push            = tag_q[BRAM_RD_LAT-1];
    assign m_tvalid        = cnt_q != '0;
    assign pop             = m_tvalid && m_tready;
    assign m_tdata         = m_tvalid ? mem_q[rd_ptr_q] : '0;
    assign m_tlast         = m_tvalid && (col_q == LAST_COL);
    assign feat_bram_addrb = addrb_q;
    assign busy            = state_q != IDLE;
    assign done            = state_q == DONE;

    // Next-state: sweep runs once per start, drains the pipeline and FIFO, then pulses done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     state_d = start ? WAIT_RDY : IDLE;
            WAIT_RDY: state_d = gat_ready ? ISSUE : WAIT_RDY;
            ISSUE:    state_d = (issue && rd_idx_q == LAST_IDX) ? DRAIN : ISSUE;
            DRAIN:    state_d = (inflight == '0 && cnt_q == '0) ? DONE : DRAIN;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Read issue, latency tags, FIFO pointers and row column counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_idx_q <= '0;
            addrb_q  <= '0;
            tag_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            col_q    <= '0;
        end else begin
            if (state_q == IDLE && start) rd_idx_q <= '0;
            else if (issue)               rd_idx_q <= rd_idx_q + 1'b1;
            if (issue) addrb_q <= {rd_idx_q, 2'b00};
            tag_q    <= tag_sh[BRAM_RD_LAT-1:0];
            wr_ptr_q <= wr_ptr_q + PW'(push);
            rd_ptr_q <= rd_ptr_q + PW'(pop);
            cnt_q    <= cnt_q + CW'(push) - CW'(pop);
            if (pop) col_q <= (col_q == LAST_COL) ? '0 : col_q + 1'b1;
        end
    end

    // FIFO storage; captures BRAM data as the matching tag leaves the pipeline.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= feat_bram_dout;
    end

    // Credit accounting must never let a capture land in a full FIFO.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && cnt_q == CW'(FIFO_DEPTH)));
endmodule
